// File: rtl/norm_l_seq_pkg.sv
// Shared G.729 encoder definitions: norm_l FSM states and 32-bit constants.
package norm_l_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          NORM_MAX = 31;
    localparam int          CNT_W    = 5;
    localparam logic [31:0] ZERO32   = 32'h0000_0000;
    localparam logic [31:0] ONES32   = 32'hFFFF_FFFF;

endpackage

// File: rtl/norm_l_seq.sv
// Sequential G.729 norm_l: counts the left shifts needed to normalise a
// signed 32-bit operand, one shift per CALC cycle.
//
// Handshake: start is sampled only while IDLE (busy=0); the operand var1 is
// captured on that same edge and may change afterwards. Starts seen while
// busy=1 are dropped. done pulses for exactly one cycle when norm, neg_norm
// and norm_val are updated; those outputs then hold until the next done.
module norm_l_seq
    import norm_l_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] var1,
    output logic        done,
    output logic        busy,
    output logic [15:0] norm,
    output logic [15:0] neg_norm,
    output logic [31:0] norm_val,
    output state_t      dbg_state
);

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_work;
    logic [31:0]        r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               r_busy;
    logic [15:0]        r_norm;
    logic [15:0]        r_neg_norm;
    logic [31:0]        r_norm_val;
    logic               w_differ;
    logic               w_special;

    // Normalised once the two top bits of the work register disagree.
    assign w_differ  = r_work[31] ^ r_work[30];
    // Zero and all-ones have fixed answers and skip the shift loop.
    assign w_special = (var1 == ZERO32) || (var1 == ONES32);

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_differ) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset takes priority over any start.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: operand capture, shift loop and result publication.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_work     <= ZERO32;
            r_shift    <= ZERO32;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_norm     <= 16'h0000;
            r_neg_norm <= 16'h0000;
            r_norm_val <= ZERO32;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work <= var1;
                        if (var1 == ONES32) begin
                            // All-ones normalises to the maximum shift.
                            r_shift <= ONES32 << NORM_MAX;
                            r_cnt   <= CNT_W'(NORM_MAX);
                        end else begin
                            r_shift <= var1;
                            r_cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    if (!w_differ) begin
                        r_work  <= r_work << 1;
                        r_shift <= r_shift << 1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done     <= 1'b1;
                    r_norm     <= {11'b0, r_cnt};
                    r_neg_norm <= 16'h0000 - {11'b0, r_cnt};
                    r_norm_val <= r_shift;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign busy      = r_busy;
    assign norm      = r_norm;
    assign neg_norm  = r_neg_norm;
    assign norm_val  = r_norm_val;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_norm_l_seq.sv
// Bench for norm_l_seq: fixed vectors, randomized operands against a
// sign-bit-counting model, and hand sequences for abort/ignore/back-to-back.
module tb_norm_l_seq;
    import norm_l_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] var1  = 32'h0;
    logic        done;
    logic        busy;
    logic [15:0] norm;
    logic [15:0] neg_norm;
    logic [31:0] norm_val;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] prev_out;

    typedef struct {
        logic [31:0] v;
        logic [15:0] n;
        logic [15:0] nn;
        logic [31:0] nv;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    norm_l_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .var1      (var1),
        .done      (done),
        .busy      (busy),
        .norm      (norm),
        .neg_norm  (neg_norm),
        .norm_val  (norm_val),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: count redundant sign bits of the operand.
    function automatic int model_norm(input logic [31:0] x);
        logic [31:0] s;
        int lz;
        if (x == 32'h0) return 0;
        s  = x[31] ? ~x : x;
        lz = 0;
        for (int i = 31; i >= 0; i--) begin
            if (s[i]) break;
            lz++;
        end
        return lz - 1;
    endfunction

    function automatic logic [63:0] model_out(input logic [31:0] x);
        int n;
        n = model_norm(x);
        return {16'(n), 16'h0000 - 16'(n), x << n};
    endfunction

    function automatic int model_lat(input logic [31:0] x);
        if (x == 32'h0 || x == 32'hFFFF_FFFF) return 2;
        return model_norm(x) + 3;
    endfunction

    // Driver + monitor for one operation. Returns #1 after the done edge
    // (or after one more edge when chk_after is set).
    task automatic do_op(input logic [31:0] v, input logic [63:0] e_out,
                         input int e_lat, input bit chk_after);
        int edges;
        bit hold_ok;
        logic [63:0] e;
        exp_q.push_back(e_out);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b1;
        var1  = v;
        @(posedge clock);
        #1;
        start = 1'b0;
        var1  = $urandom;
        edges = 1;
        hold_ok = 1'b1;
        check("busy_after_accept", 64'(busy), 64'(1));
        while (!done && edges < 40) begin
            if ({norm, neg_norm, norm_val} !== prev_out) hold_ok = 1'b0;
            @(posedge clock);
            #1;
            edges++;
        end
        e = exp_q.pop_front();
        check("done_seen", 64'(done), 64'(1));
        check("latency", 64'(edges), 64'(e_lat));
        check("result", {norm, neg_norm, norm_val}, e);
        check("held_until_done", 64'(hold_ok), 64'(1));
        check("busy_at_done", 64'(busy), 64'(0));
        prev_out = e;
        if (chk_after) begin
            @(posedge clock);
            #1;
            check("done_one_cycle", 64'(done), 64'(0));
            check("held_after", {norm, neg_norm, norm_val}, e);
        end
    endtask

    initial begin
        int dones;
        int first;
        logic [31:0] r;
        logic [31:0] v;
        int sh;

        tbl[0] = '{32'h0000_0001, 16'd30, 16'hFFE2, 32'h4000_0000, 33};
        tbl[1] = '{32'h0000_0000, 16'd0,  16'h0000, 32'h0000_0000, 2};
        tbl[2] = '{32'hFFFF_FFFF, 16'd31, 16'hFFE1, 32'h8000_0000, 2};
        tbl[3] = '{32'hFFFF_8000, 16'd16, 16'hFFF0, 32'h8000_0000, 19};
        tbl[4] = '{32'h8000_0000, 16'd0,  16'h0000, 32'h8000_0000, 3};
        tbl[5] = '{32'h0000_4000, 16'd16, 16'hFFF0, 32'h4000_0000, 19};
        tbl[6] = '{32'h7FFF_FFFF, 16'd0,  16'h0000, 32'h7FFF_FFFF, 3};
        tbl[7] = '{32'hFFFF_FFFE, 16'd30, 16'hFFE2, 32'h8000_0000, 33};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_outputs", {norm, neg_norm, norm_val}, 64'h0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        prev_out = 64'h0;

        // Fixed vectors; the first start lands on the first edge after reset drops.
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].v, {tbl[i].n, tbl[i].nn, tbl[i].nv}, tbl[i].lat, 1'b1);
        end

        // Start reasserted mid-CALC with another operand is dropped.
        @(negedge clock);
        start = 1'b1;
        var1  = 32'h0000_0001;
        @(posedge clock);
        #1;
        start = 1'b0;
        var1  = 32'h0;
        dones = 0;
        first = 0;
        for (int e = 2; e <= 40; e++) begin
            start = (e == 6);
            if (e == 6) var1 = 32'h1234_5678;
            @(posedge clock);
            #1;
            if (done) begin
                dones++;
                if (first == 0) first = e;
            end
        end
        start = 1'b0;
        check("ignore_single_done", 64'(dones), 64'(1));
        check("ignore_latency", 64'(first), 64'(33));
        check("ignore_result", {norm, neg_norm, norm_val}, model_out(32'h0000_0001));
        prev_out = model_out(32'h0000_0001);

        // Reset at edge 10 aborts an operation with no done pulse.
        @(negedge clock);
        start = 1'b1;
        var1  = 32'h0000_0001;
        @(posedge clock);
        #1;
        start = 1'b0;
        dones = 0;
        for (int e = 2; e <= 10; e++) begin
            if (e == 10) reset = 1'b1;
            @(posedge clock);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'(0));
        check("abort_outputs", {norm, neg_norm, norm_val}, 64'h0);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        prev_out = 64'h0;
        do_op(32'hFFFF_8000, model_out(32'hFFFF_8000), model_lat(32'hFFFF_8000), 1'b0);

        // Back-to-back: next start raised while done is still high.
        do_op(32'h0000_00FF, model_out(32'h0000_00FF), model_lat(32'h0000_00FF), 1'b0);
        do_op(32'hFFFF_FFFF, model_out(32'hFFFF_FFFF), 2, 1'b0);
        do_op(32'h0123_4567, model_out(32'h0123_4567), model_lat(32'h0123_4567), 1'b1);

        // Randomized operands spread across all shift counts.
        for (int i = 0; i < 150; i++) begin
            r  = $urandom;
            sh = $urandom_range(0, 31);
            case ($urandom_range(0, 2))
                0:       v = r >> sh;
                1:       v = $signed(r) >>> sh;
                default: v = r;
            endcase
            do_op(v, model_out(v), model_lat(v), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
